multicycle_cpu_core: RTL
========================

# multicycle_cpu_core

Parametrised multi-cycle successor to the single-cycle 8-bit CPU. It executes the same two-byte instruction set through an explicit fetch/execute/memory state machine. Instruction ROM and data RAM sit outside the block and are reached over req/ready handshakes, so wait states are supported. Carry and zero are registered architectural flags, and the core adds a HALT instruction.

## Interface
- DATA_W, 8, register/ALU/memory data width; legal range 8..32.
- PC_W, 8, program counter and ROM address width; legal range 8..16.
- clk  in  1  single clock; all state updates on posedge.
- n_reset  in  1  synchronous, active-low reset, sampled on posedge clk.
- rom_req  out  1  instruction fetch request.
- rom_address  out  PC_W  fetch address (= PC).
- rom_ready  in  1  fetch complete; rom_data valid in the same cycle.
- rom_data  in  16  instruction; [15:8]=opcode1, [7:0]=opcode2.
- mem_req  out  1  data access request.
- mem_we  out  1  1=store, 0=load; valid while mem_req=1.
- mem_addr  out  8  data address (= opcode2).
- mem_wdata  out  DATA_W  store data.
- mem_ready  in  1  access complete; mem_rdata valid in the same cycle on loads.
- mem_rdata  in  DATA_W  load data.
- carry_f  out  1  registered carry flag.
- zero_f  out  1  registered zero flag.
- halted  out  1  core is in HALT.

## Operation
- State: 16 x DATA_W register file R0..R15, PC, IR (16 bits), carry, zero, FSM.
- Field names: op1=IR[15:8], op2=IR[7:0]; ra=op1[3:0], rs=op2[7:4], rd=op2[3:0].
- Decode on op1[7:4]:
  - 1xxx ALU: R[rd] = R[ra] op R[rs]; func=op1[6:4]; flags are updated.
  - 0001 LDI: R[ra] = zero-extended op2.
  - 0010 LD: R[ra] = mem[op2].
  - 0011 ST: mem[op2] = R[ra].
  - 0100 jump, target = zero-extended op2. op1[2:0]: 000 JMP, 001 JC, 101 JNC, 010 JZ, 110 JNZ; any other value is a NOP.
  - 0000 HALT.
  - 0101..0111 NOP.
- ALU functions, all results mod 2^DATA_W:
  - 000 ADD; C = carry-out of bit DATA_W-1.
  - 001 SUB; C = borrow (1 iff R[ra] < R[rs], unsigned).
  - 010 AND, 011 OR, 100 XOR; C=0.
  - 101 NOT R[ra]; C=0.
  - 110 ROL; C = old MSB.
  - 111 ROR; C = old LSB.
  - Z = (result == 0).
- Only ALU instructions modify flags. Jumps read the flags as they stand after the previous instruction.
- FSM states: FETCH, EXEC, MEM, HALT.
  - FETCH: rom_req=1, rom_address=PC. When rom_ready=1: IR <= rom_data, go to EXEC.
  - EXEC, ALU/LDI/NOP: register write, PC <= PC+2, go to FETCH.
  - EXEC, jump: PC <= target if the condition is true, else PC+2; go to FETCH.
  - EXEC, LD/ST: go to MEM.
  - EXEC, HALT: go to HALT.
  - MEM: mem_req=1, mem_we=ST, mem_addr=op2, mem_wdata=R[ra]. When mem_ready=1: LD writes R[ra] <= mem_rdata; PC <= PC+2; go to FETCH.
  - HALT: terminal; halted=1, no requests. Only reset exits.
- PC arithmetic is mod 2^PC_W; 2^PC_W-2 + 2 wraps to 0.
- ALU with rd == ra or rd == rs: operands are read before the write, so there is no hazard.

## Timing
- Reset (n_reset=0 at a posedge) clears on that edge: PC=0, IR=0, all registers=0, carry=zero=0, state=FETCH.
- Outputs on the reset edge and the cycle after it: rom_req=1 with rom_address=0; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0; halted=0.
- Reset mid-transaction abandons the access; the interrupted instruction has no architectural effect.
- Handshakes:
  - req is asserted from the state's first cycle and held, with address/we/wdata stable, until ready is sampled 1.
  - req deasserts in the cycle after completion.
  - ready while req=0 is ignored.
- Latency with zero wait states:
  - ALU, LDI, jump, NOP, HALT: 2 cycles (FETCH + EXEC).
  - LD, ST: 3 cycles.
  - Each ready-low cycle adds exactly 1 cycle.
- Register-file and flag writes take effect at the end of EXEC (or MEM for LD). The next instruction's EXEC sees the new values.
- carry_f, zero_f and halted are register outputs; they change only on posedge.

## Test plan
- Reset, then LDI R1,0x7F; LDI R2,0x01; ADD (op1=0x81, op2=0x23) -> R3=0x80, C=0, Z=0. Each instruction takes 2 cycles; PC reads 6 after the third.
- LDI R1,0xFF; LDI R2,0x01; ADD into R3 -> R3=0x00, C=1, Z=1. Then JZ 0x40 -> next rom_address=0x40. JNZ at the same point -> PC+2.
- ST R1 to 0x10 with mem_ready held low 3 cycles -> mem_req high 4 cycles, mem_addr=0x10, mem_wdata=0xFF, mem_we=1, stable throughout. LD R4 from 0x10 (mem_rdata=0xFF) -> R4=0xFF.
- DATA_W=16: LDI R1,0x01; ROR R1 -> R1=0x8000, C=1. SUB 0x0000-0x0001 -> 0xFFFF, C=1.
- Drop n_reset low during a stalled FETCH at PC=0x20 -> next cycle rom_address=0, all registers and flags 0, mem_req=0.
- HALT at PC=0x0A -> halted=1 two cycles after the fetch is issued. rom_req and mem_req stay 0 indefinitely; PC stays 0x0A until reset.

Source files
------------

// File: rtl/multicycle_cpu_core.sv
// multicycle_cpu_core: two-byte ISA executed as FETCH/EXEC/MEM/HALT
// with req/ready instruction and data ports and registered flags.
module multicycle_cpu_core #(
   parameter int DATA_W = 8,
   parameter int PC_W   = 8
) (
   input  logic              clk,
   input  logic              n_reset,
   output logic              rom_req,
   output logic [PC_W-1:0]   rom_address,
   input  logic              rom_ready,
   input  logic [15:0]       rom_data,
   output logic              mem_req,
   output logic              mem_we,
   output logic [7:0]        mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              carry_f,
   output logic              zero_f,
   output logic              halted
);

   typedef enum logic [1:0] {
      S_FETCH,
      S_EXEC,
      S_MEM,
      S_HALT
   } state_t;

   state_t            state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [15:0]       ir_q, ir_d;
   logic              carry_q, carry_d;
   logic              zero_q, zero_d;
   logic [DATA_W-1:0] rf_q [16];

   logic              rf_we;
   logic [3:0]        rf_wa;
   logic [DATA_W-1:0] rf_wd;

   logic [7:0]        op1, op2;
   logic [3:0]        ra, rs, rd;
   logic [DATA_W-1:0] a, b;
   logic [DATA_W:0]   alu_w;
   logic              take;
   logic [PC_W-1:0]   pc_inc, target;
   logic              is_alu, is_ldi, is_ld;
   logic              is_st, is_jmp, is_halt;

   assign op1 = ir_q[15:8];
   assign op2 = ir_q[7:0];
   assign ra  = op1[3:0];
   assign rs  = op2[7:4];
   assign rd  = op2[3:0];
   assign a   = rf_q[ra];
   assign b   = rf_q[rs];

   assign is_alu  = op1[7];
   assign is_ldi  = op1[7:4] == 4'b0001;
   assign is_ld   = op1[7:4] == 4'b0010;
   assign is_st   = op1[7:4] == 4'b0011;
   assign is_jmp  = op1[7:4] == 4'b0100;
   assign is_halt = op1[7:4] == 4'b0000;

   assign pc_inc = pc_q + PC_W'(2);
   assign target = PC_W'(op2);

   // ALU result with the carry/borrow in the extra top bit
   always_comb begin
      alu_w = '0;
      unique case (op1[6:4])
         3'd0: alu_w = {1'b0, a} + {1'b0, b};
         3'd1: alu_w = {1'b0, a} - {1'b0, b};
         3'd2: alu_w = {1'b0, a & b};
         3'd3: alu_w = {1'b0, a | b};
         3'd4: alu_w = {1'b0, a ^ b};
         3'd5: alu_w = {1'b0, ~a};
         3'd6: alu_w = {a[DATA_W-1], a[DATA_W-2:0], a[DATA_W-1]};
         3'd7: alu_w = {a[0], a[0], a[DATA_W-1:1]};
      endcase
   end

   // jump condition from flags left by the previous instruction
   always_comb begin
      take = 1'b0;
      unique case (op1[2:0])
         3'b000:  take = 1'b1;
         3'b001:  take = carry_q;
         3'b101:  take = ~carry_q;
         3'b010:  take = zero_q;
         3'b110:  take = ~zero_q;
         default: take = 1'b0;
      endcase
   end

   // sequencing, PC/IR/flag next state and register-file write port
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      carry_d = carry_q;
      zero_d  = zero_q;
      rf_we   = 1'b0;
      rf_wa   = ra;
      rf_wd   = alu_w[DATA_W-1:0];
      unique case (state_q)
         S_FETCH: begin
            if (rom_ready) begin
               ir_d    = rom_data;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            pc_d    = pc_inc;
            state_d = S_FETCH;
            unique case (1'b1)
               is_alu: begin
                  rf_we   = 1'b1;
                  rf_wa   = rd;
                  carry_d = alu_w[DATA_W];
                  zero_d  = alu_w[DATA_W-1:0] == '0;
               end
               is_ldi: begin
                  rf_we = 1'b1;
                  rf_wd = DATA_W'(op2);
               end
               is_jmp: begin
                  if (take) pc_d = target;
               end
               is_ld, is_st: begin
                  pc_d    = pc_q;
                  state_d = S_MEM;
               end
               is_halt: begin
                  pc_d    = pc_q;
                  state_d = S_HALT;
               end
               default: ;
            endcase
         end
         S_MEM: begin
            if (mem_ready) begin
               pc_d    = pc_inc;
               state_d = S_FETCH;
               rf_we   = is_ld;
               rf_wd   = mem_rdata;
            end
         end
         S_HALT: ;
         default: state_d = S_FETCH;
      endcase
   end

   // architectural state; reset also abandons any open access
   always_ff @(posedge clk) begin
      if (!n_reset) begin
         state_q <= S_FETCH;
         pc_q    <= '0;
         ir_q    <= '0;
         carry_q <= 1'b0;
         zero_q  <= 1'b0;
         for (int i = 0; i < 16; i++) rf_q[i] <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         carry_q <= carry_d;
         zero_q  <= zero_d;
         if (rf_we) rf_q[rf_wa] <= rf_wd;
      end
   end

   assign rom_req     = state_q == S_FETCH;
   assign rom_address = pc_q;
   assign mem_req     = state_q == S_MEM;
   assign mem_we      = mem_req & is_st;
   assign mem_addr    = mem_req ? op2 : '0;
   assign mem_wdata   = mem_req ? a : '0;
   assign carry_f     = carry_q;
   assign zero_f      = zero_q;
   assign halted      = state_q == S_HALT;

endmodule
